// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the 5-stage MIPS core pipeline stages.
// Contents:
//    ALU_*        4-bit ALU opcodes as decoded by ID and consumed by EX
//    CTRL_*       bit positions inside the 4-bit control bundle
//                 {reg_write, mem_read, mem_write, mem_to_reg}
//    CTRL_BUBBLE  control bundle value that has no architectural effect
package mips_pkg;

   localparam logic [3:0] ALU_SLL = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0110;
   localparam logic [3:0] ALU_LUI = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1010;
   localparam logic [3:0] ALU_SRL = 4'b1111;

   localparam int CTRL_RW  = 3;
   localparam int CTRL_MR  = 2;
   localparam int CTRL_MW  = 1;
   localparam int CTRL_M2R = 0;

   localparam logic [3:0] CTRL_BUBBLE = 4'b0000;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
// Resolves one EX-stage source operand against the two younger pipeline
// results that have not yet been written to the register file.
// Ports:
//    src              register index this operand was read from
//    reg_data         value the register file supplied in ID
//    exmem_reg_write  EX/MEM instruction writes a register
//    exmem_rd         EX/MEM destination index
//    exmem_alu_res    EX/MEM ALU result
//    memwb_reg_write  MEM/WB instruction writes a register
//    memwb_rd         MEM/WB destination index
//    memwb_wdata      MEM/WB writeback value
//    fwd_data         most recent value of register src
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_alu_res,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_wdata,
   output logic [DATA_W-1:0] fwd_data
);

   // EX/MEM is the youngest producer, so it wins over MEM/WB when both
   // target the same register. Register 0 is hard-wired and never
   // forwards; whatever the register file supplied passes through.
   always_comb begin
      fwd_data = reg_data;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src)) begin
         fwd_data = exmem_alu_res;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src)) begin
         fwd_data = memwb_wdata;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection.
// Ports:
//    clk, rst            core clock, asynchronous active-high reset
//    flush               branch/jump redirect; the ID instruction is killed
//    id_*                decoded operands and control from ID
//    exmem_*, memwb_*    younger results available for forwarding
//    stall               hold PC and IF/ID this cycle (combinational)
//    data1, data2        ALU operands (forwarded rs; immediate or forwarded rt)
//    shamt, alu_ctrl     ALU shift amount and opcode
//    ex_store_data       forwarded rt, carried on for stores
//    ex_rd, ex_ctrl      destination and control bundle carried on to EX/MEM
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_shamt,
   input  logic [3:0]        id_alu_ctrl,
   input  logic              id_alu_src,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [3:0]        id_ctrl,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_alu_res,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic [5:0]        shamt,
   output logic [3:0]        alu_ctrl,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        ex_ctrl
);

   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [4:0]        ex_shamt;
   logic              ex_alu_src;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic              hz;
   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;

   // A load in EX cannot supply its data until after MEM, so an ID
   // instruction that reads the load's destination must wait one cycle.
   // A flush kills that ID instruction anyway, so no stall is needed then.
   always_comb begin
      hz = ex_ctrl[CTRL_MR] && (ex_rd != '0) &&
           ((id_rs == ex_rd) || (id_use_rt && (id_rt == ex_rd)));
      stall = hz && !flush;
   end

   // The register bank. Flush and hazard both load an all-zero bubble; the
   // bubble decodes as SLL of register 0 with no control side effects, and
   // zero source indices guarantee it never picks up forwarded data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_shamt   <= '0;
         alu_ctrl   <= ALU_SLL;
         ex_alu_src <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_ctrl    <= CTRL_BUBBLE;
      end else if (flush || hz) begin
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_shamt   <= '0;
         alu_ctrl   <= ALU_SLL;
         ex_alu_src <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_ctrl    <= CTRL_BUBBLE;
      end else begin
         ex_rs_data <= id_rs_data;
         ex_rt_data <= id_rt_data;
         ex_imm     <= id_imm;
         ex_shamt   <= id_shamt;
         alu_ctrl   <= id_alu_ctrl;
         ex_alu_src <= id_alu_src;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
         ex_ctrl    <= id_ctrl;
      end
   end

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .src             (ex_rs),
      .reg_data        (ex_rs_data),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_alu_res   (exmem_alu_res),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_wdata     (memwb_wdata),
      .fwd_data        (rs_fwd)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .src             (ex_rt),
      .reg_data        (ex_rt_data),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_alu_res   (exmem_alu_res),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_wdata     (memwb_wdata),
      .fwd_data        (rt_fwd)
   );

   // Operand selection for the ALU. Stores always need the forwarded rt
   // even though their ALU operand 2 is the immediate offset.
   always_comb begin
      data1         = rs_fwd;
      data2         = ex_alu_src ? ex_imm : rt_fwd;
      ex_store_data = rt_fwd;
      shamt         = {1'b0, ex_shamt};
   end

endmodule
